elevator_plant: RTL and testbench

//   Behavioural model of the elevator shaft, cabin and door, i.e. the physical plant.
//   It receives the motor and door commands issued by the controller top (Main).
//   It returns the floor-alignment sensors and door end-stop sensors the controller consumes.
//   It sits in the bench/FPGA demo between the controller outputs and its sensor inputs,

---
 rtl/elevator_plant.sv | 127 ++++++++++++
 tb/tb_elevator_plant.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/elevator_plant.sv
// Elevator plant model: cabin position, door position and a sticky safety
// fault, advanced on tick and fed back to the controller as end-stop sensors.
// Ports:
//   clk, reset0 (sync, active-high), tick (advance enable)
//   mot[1:0] motor command, door_cmd[1:0] {open,close}
//   floor_sens, floor_code, door_open, door_closed, moving, fault, fault_code
module elevator_plant #(
  parameter int FLOORS       = 3,
  parameter int TRAVEL_TICKS = 4,
  parameter int DOOR_TICKS   = 2
) (
  input  logic              clk,
  input  logic              reset0,
  input  logic              tick,
  input  logic [1:0]        mot,
  input  logic [1:0]        door_cmd,
  output logic [FLOORS-1:0] floor_sens,
  output logic [1:0]        floor_code,
  output logic              door_open,
  output logic              door_closed,
  output logic              moving,
  output logic              fault,
  output logic [1:0]        fault_code
);

  localparam int OW = $clog2(TRAVEL_TICKS);
  localparam int DW = $clog2(DOOR_TICKS + 1);
  localparam logic [1:0]    TOP  = 2'(FLOORS - 1);
  localparam logic [OW-1:0] OMAX = OW'(TRAVEL_TICKS - 1);
  localparam logic [DW-1:0] DMAX = DW'(DOOR_TICKS);

  logic [1:0]    f, f_n;
  logic [OW-1:0] o, o_n;
  logic [DW-1:0] d, d_n;
  logic          mv_n;
  logic [1:0]    code_n;

  logic aligned, up, dn, inv, opn, cls;
  logic ovr, ilk, dbad;

  assign aligned = (o == '0);
  assign up      = (mot == 2'b01);
  assign dn      = (mot == 2'b10);
  assign inv     = (mot == 2'b11);
  assign opn     = (door_cmd == 2'b10);
  assign cls     = (door_cmd == 2'b01);

  assign ovr  = aligned &&
                ((up && f == TOP) || (dn && f == 2'd0));
  assign ilk  = (up || dn) && (d != '0);
  assign dbad = opn && (!aligned || mot != 2'b00);

  always_comb begin
    f_n    = f;
    o_n    = o;
    d_n    = d;
    mv_n   = 1'b0;
    code_n = 2'b00;
    // Highest-severity fault wins when several fire on one tick.
    if (inv || ovr)
      code_n = 2'b11;
    else if (ilk)
      code_n = 2'b01;
    else if (dbad)
      code_n = 2'b10;

    // Any fault on this tick freezes cabin and door.
    if (code_n == 2'b00) begin
      if (up) begin
        mv_n = 1'b1;
        if (o == OMAX) begin
          f_n = f + 2'd1;
          o_n = '0;
        end else begin
          o_n = o + 1'b1;
        end
      end else if (dn) begin
        mv_n = 1'b1;
        if (o == '0) begin
          f_n = f - 2'd1;
          o_n = OMAX;
        end else begin
          o_n = o - 1'b1;
        end
      end
      if (opn && d != DMAX)
        d_n = d + 1'b1;
      else if (cls && d != '0)
        d_n = d - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset0) begin
      f          <= 2'd0;
      o          <= '0;
      d          <= '0;
      moving     <= 1'b0;
      fault      <= 1'b0;
      fault_code <= 2'b00;
    end else if (tick) begin
      if (!fault) begin
        f      <= f_n;
        o      <= o_n;
        d      <= d_n;
        moving <= mv_n;
        if (code_n != 2'b00) begin
          fault      <= 1'b1;
          fault_code <= code_n;
        end
      end else begin
        moving <= 1'b0;
      end
    end
  end

  always_comb begin
    floor_sens = '0;
    for (int i = 0; i < FLOORS; i++)
      floor_sens[i] = aligned && (f == 2'(i));
  end

  assign floor_code  = f;
  assign door_open   = (d == DMAX);
  assign door_closed = (d == '0);

endmodule

// File: tb/tb_elevator_plant.sv
// Directed bench for elevator_plant: travel, door cycling, interlock,
// overrun, invalid command, off-floor door open, reset and tick gating.
module tb_elevator_plant;

  logic       clk = 1'b0;
  logic       reset0 = 1'b1;
  logic       tick = 1'b0;
  logic [1:0] mot = 2'b00;
  logic [1:0] door_cmd = 2'b00;
  logic [2:0] floor_sens;
  logic [1:0] floor_code;
  logic       door_open, door_closed, moving, fault;
  logic [1:0] fault_code;

  int n_assert = 0;
  int n_fail   = 0;

  elevator_plant #(
    .FLOORS(3), .TRAVEL_TICKS(4), .DOOR_TICKS(2)
  ) dut (
    .clk(clk), .reset0(reset0), .tick(tick),
    .mot(mot), .door_cmd(door_cmd),
    .floor_sens(floor_sens), .floor_code(floor_code),
    .door_open(door_open), .door_closed(door_closed),
    .moving(moving), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tk(input logic [1:0] m, input logic [1:0] dc);
    @(negedge clk);
    mot = m;
    door_cmd = dc;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    mot = 2'b00;
    door_cmd = 2'b00;
  endtask

  task automatic rst();
    @(negedge clk);
    reset0 = 1'b1;
    @(negedge clk);
    reset0 = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_sens"}, 8'(floor_sens), 8'h1);
    chk({tag, "_code"}, 8'(floor_code), 8'h0);
    chk({tag, "_closed"}, 8'(door_closed), 8'h1);
    chk({tag, "_open"}, 8'(door_open), 8'h0);
    chk({tag, "_moving"}, 8'(moving), 8'h0);
    chk({tag, "_fault"}, 8'(fault), 8'h0);
    chk({tag, "_fcode"}, 8'(fault_code), 8'h0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset0 = 1'b0;
    chk_reset("rst0");

    // Travel floor 0 -> 1.
    for (int i = 1; i <= 3; i++) begin
      tk(2'b01, 2'b00);
      chk($sformatf("up_t%0d_sens", i), 8'(floor_sens), 8'h0);
      chk($sformatf("up_t%0d_mov", i), 8'(moving), 8'h1);
      chk($sformatf("up_t%0d_code", i), 8'(floor_code), 8'h0);
    end
    tk(2'b01, 2'b00);
    chk("up_t4_sens", 8'(floor_sens), 8'h2);
    chk("up_t4_code", 8'(floor_code), 8'h1);
    chk("up_t4_mov", 8'(moving), 8'h1);

    // tick low: commands ignored.
    @(negedge clk);
    mot = 2'b01;
    door_cmd = 2'b10;
    repeat (3) @(negedge clk);
    mot = 2'b00;
    door_cmd = 2'b00;
    chk("hold_sens", 8'(floor_sens), 8'h2);
    chk("hold_mov", 8'(moving), 8'h1);
    chk("hold_closed", 8'(door_closed), 8'h1);

    // Door cycle at floor 1.
    tk(2'b00, 2'b10);
    chk("open1_closed", 8'(door_closed), 8'h0);
    chk("open1_open", 8'(door_open), 8'h0);
    chk("open1_mov", 8'(moving), 8'h0);
    tk(2'b00, 2'b10);
    chk("open2_open", 8'(door_open), 8'h1);
    tk(2'b00, 2'b10);
    chk("open_sat", 8'(door_open), 8'h1);
    chk("open_sat_fault", 8'(fault), 8'h0);
    tk(2'b00, 2'b01);
    chk("close1_closed", 8'(door_closed), 8'h0);
    chk("close1_open", 8'(door_open), 8'h0);
    tk(2'b00, 2'b01);
    chk("close2_closed", 8'(door_closed), 8'h1);
    tk(2'b00, 2'b01);
    chk("close_sat", 8'(door_closed), 8'h1);
    chk("close_sat_fault", 8'(fault), 8'h0);

    // Interlock: door half open, motor up.
    tk(2'b00, 2'b10);
    tk(2'b01, 2'b00);
    chk("ilk_fault", 8'(fault), 8'h1);
    chk("ilk_fcode", 8'(fault_code), 8'h1);
    chk("ilk_sens", 8'(floor_sens), 8'h2);
    chk("ilk_mov", 8'(moving), 8'h0);
    tk(2'b10, 2'b10);
    tk(2'b11, 2'b01);
    chk("frz_fcode", 8'(fault_code), 8'h1);
    chk("frz_sens", 8'(floor_sens), 8'h2);
    chk("frz_closed", 8'(door_closed), 8'h0);
    chk("frz_open", 8'(door_open), 8'h0);

    // Overrun at top.
    rst();
    chk_reset("rst1");
    repeat (8) tk(2'b01, 2'b00);
    chk("top_sens", 8'(floor_sens), 8'h4);
    chk("top_code", 8'(floor_code), 8'h2);
    tk(2'b01, 2'b00);
    chk("ovr_up_fcode", 8'(fault_code), 8'h3);
    chk("ovr_up_sens", 8'(floor_sens), 8'h4);
    chk("ovr_up_mov", 8'(moving), 8'h0);

    // Overrun at bottom.
    rst();
    tk(2'b10, 2'b00);
    chk("ovr_dn_fcode", 8'(fault_code), 8'h3);
    chk("ovr_dn_sens", 8'(floor_sens), 8'h1);

    // Down travel from floor 1 passes through offset 3.
    rst();
    repeat (4) tk(2'b01, 2'b00);
    tk(2'b10, 2'b00);
    chk("dn1_sens", 8'(floor_sens), 8'h0);
    chk("dn1_code", 8'(floor_code), 8'h0);
    repeat (3) tk(2'b10, 2'b00);
    chk("dn4_sens", 8'(floor_sens), 8'h1);
    chk("dn4_fault", 8'(fault), 8'h0);

    // Invalid motor command.
    rst();
    tk(2'b11, 2'b00);
    chk("inv_fcode", 8'(fault_code), 8'h3);
    chk("inv_sens", 8'(floor_sens), 8'h1);

    // Overrun outranks interlock.
    rst();
    tk(2'b00, 2'b10);
    tk(2'b10, 2'b00);
    chk("pri_fcode", 8'(fault_code), 8'h3);

    // Interlock outranks off-floor open; no move.
    rst();
    tk(2'b00, 2'b10);
    tk(2'b01, 2'b10);
    chk("pri2_fcode", 8'(fault_code), 8'h1);
    chk("pri2_sens", 8'(floor_sens), 8'h1);

    // Open while motor commanded at floor.
    rst();
    tk(2'b01, 2'b10);
    chk("opnmot_fcode", 8'(fault_code), 8'h2);
    chk("opnmot_sens", 8'(floor_sens), 8'h1);
    chk("opnmot_closed", 8'(door_closed), 8'h1);

    // Open mid-travel.
    rst();
    repeat (2) tk(2'b01, 2'b00);
    tk(2'b00, 2'b10);
    chk("mid_fcode", 8'(fault_code), 8'h2);
    chk("mid_sens", 8'(floor_sens), 8'h0);
    chk("mid_closed", 8'(door_closed), 8'h1);

    // Reset overrides tick.
    @(negedge clk);
    reset0 = 1'b1;
    tick = 1'b1;
    mot = 2'b01;
    @(negedge clk);
    reset0 = 1'b0;
    tick = 1'b0;
    mot = 2'b00;
    chk_reset("rst2");

    // Commands with tick low after reset.
    @(negedge clk);
    mot = 2'b01;
    door_cmd = 2'b10;
    repeat (4) @(negedge clk);
    mot = 2'b00;
    door_cmd = 2'b00;
    chk_reset("idle");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
